nrisc_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit NRISC core, sitting between separate instruction and data memories. It adds configurable data and address widths, a multi-cycle FSM with valid/ready memory handshakes that tolerate wait states, a HALT instruction, and external pause at instruction boundaries. The ISA stays an 8-bit encoding over four general registers.

---
 rtl/nrisc_mc.sv | 177 +++++++++++++++++
 tb/tb_nrisc_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_mc.sv
// nrisc_mc -- multi-cycle NRISC core between separate instruction and data memories.
//
// Executes the 8-bit NRISC encoding (op=[7:4], rd=[3:2], rs=[1:0]) over four
// W-bit registers. One instruction completes before the next fetch, so there
// is no forwarding. Memory accesses use valid/ready handshakes and tolerate
// any number of wait states. The PC and addresses are AW bits wide.
//
// Optional feature macro: NRISC_MUL_EN
//   defined   -> opcode B is MUL (low W bits of R[rd]*R[rs]), single-cycle EXEC
//   undefined -> opcode B is a NOP and no multiplier is built
//
// Parameters:
//   W   data/register width (>= 4)
//   AW  instruction/data address width, also the PC width
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   halt                     pause request, taken only at instruction boundaries
//   imem_req/addr/data/ready instruction fetch handshake (addr == pc)
//   dmem_req/we/addr/wdata/rdata/ready  data access handshake
//   pc                       address of the current or next instruction
//   halted                   high once a HALT instruction has executed

module nrisc_mc #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [7:0]    imem_data,
    input  logic          imem_ready,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [W-1:0]  dmem_wdata,
    input  logic [W-1:0]  dmem_rdata,
    input  logic          dmem_ready,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_LI   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JR   = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state, state_nxt;
    logic [7:0]          ir;
    logic [3:0][W-1:0]   regs;

    logic [3:0]          op;
    logic [1:0]          rd, rs;
    logic [W-1:0]        a, b;
    logic [W-1:0]        res;
    logic                res_wr;
    logic [AW-1:0]       pc_exec;

    // Low AW bits of a register value, zero-extended when W < AW.
    function automatic logic [AW-1:0] to_addr(input logic [W-1:0] v);
        logic [W+AW-1:0] ext;
        ext = {{AW{1'b0}}, v};
        return ext[AW-1:0];
    endfunction

    assign op = ir[7:4];
    assign rd = ir[3:2];
    assign rs = ir[1:0];
    assign a  = regs[rd];
    assign b  = regs[rs];

    // Execute datapath: result, writeback enable and next pc for EXEC.
    // Operands are the registers as they stand before EXEC, so a BEQ target
    // is never affected by its own writeback.
    always_comb begin
        res     = '0;
        res_wr  = 1'b0;
        pc_exec = pc + AW'(1);
        case (op)
            OP_ADD: begin res = a + b; res_wr = 1'b1; end
            OP_SUB: begin res = a - b; res_wr = 1'b1; end
            OP_AND: begin res = a & b; res_wr = 1'b1; end
            OP_OR:  begin res = a | b; res_wr = 1'b1; end
            OP_SLT: begin
                res    = ($signed(a) < $signed(b)) ? W'(1) : '0;
                res_wr = 1'b1;
            end
            OP_LI:  begin res = {{(W-2){ir[1]}}, ir[1:0]}; res_wr = 1'b1; end
            OP_SHL: begin res = {a[W-2:0], 1'b0}; res_wr = 1'b1; end
`ifdef NRISC_MUL_EN
            OP_MUL: begin res = W'(a * b); res_wr = 1'b1; end
`endif
            OP_BEQ:  if (a == b) pc_exec = to_addr(regs[0]);
            OP_JR:   pc_exec = to_addr(b);
            OP_HALT: pc_exec = pc;
            default: ;
        endcase
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        halted    = 1'b0;
        case (state)
            S_IDLE:  if (!halt) state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
                else if (op == OP_HALT)         state_nxt = S_HALTED;
                else                            state_nxt = halt ? S_IDLE : S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) state_nxt = halt ? S_IDLE : S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            regs       <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH: if (imem_ready) ir <= imem_data;
                S_EXEC: begin
                    pc <= pc_exec;
                    if (res_wr) regs[rd] <= res;
                    // Data request fields are captured once here so they stay
                    // stable for the whole MEM handshake.
                    if (op == OP_LD || op == OP_ST) begin
                        dmem_addr  <= to_addr(b);
                        dmem_we    <= (op == OP_ST);
                        dmem_wdata <= a;
                    end
                end
                S_MEM: if (dmem_ready && !dmem_we) regs[rd] <= dmem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_mc.sv
// Self-checking bench for nrisc_mc (W = AW = 8): directed scenarios from the
// test plan, then a random program with random wait states and halt pulses,
// checked at every fetch handshake against an instruction-level model.

module tb_nrisc_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       halt = 1'b0;
    logic       imem_req, dmem_req, dmem_we, halted;
    logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [7:0] imem_data;
    logic       imem_ready = 1'b1;
    logic       dmem_ready = 1'b1;

    logic [7:0] imem [256];
    logic [7:0] dmem [256];

    int n_chk  = 0;
    int n_fail = 0;

    // instruction-level reference model state
    logic [7:0] m_pc;
    logic [7:0] m_r  [4];
    logic [7:0] m_dm [256];
    bit         rnd_mode = 1'b0;
    bit         rnd_done = 1'b0;
    int         n_fetch  = 0;
    localparam int N_RND = 400;

    nrisc_mc #(.W(8), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk)
        if (!rst && dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] <= dmem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rg(input int i);
        return 32'(dut.regs[i]);
    endfunction

    // Execute one instruction at the architectural level.
    task automatic model_step();
        logic [7:0] ins, x, y, nxt;
        logic [1:0] d, s;
        ins = imem[m_pc];
        d   = ins[3:2];
        s   = ins[1:0];
        x   = m_r[d];
        y   = m_r[s];
        nxt = m_pc + 8'd1;
        case (ins[7:4])
            4'h0: m_r[d] = x + y;
            4'h1: m_r[d] = x - y;
            4'h2: m_r[d] = x & y;
            4'h3: m_r[d] = x | y;
            4'h4: m_r[d] = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            4'h5: m_r[d] = 8'($signed(ins[1:0]));
            4'h6: m_r[d] = m_dm[y];
            4'h7: m_dm[y] = x;
            4'h8: if (x == y) nxt = m_r[0];
            4'h9: nxt = y;
            4'hA: m_r[d] = x * 8'd2;
`ifdef NRISC_MUL_EN
            4'hB: m_r[d] = 8'(int'(x) * int'(y));
`endif
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // At a fetch handshake every earlier instruction has retired, so the
    // architectural state must match the model exactly.
    task automatic model_fetch();
        check("rnd_pc", 32'(imem_addr), 32'(m_pc));
        for (int i = 0; i < 4; i++) check($sformatf("rnd_r%0d", i), rg(i), 32'(m_r[i]));
        n_fetch++;
        if (n_fetch == N_RND) begin
            for (int i = 0; i < 256; i++) check("rnd_dmem", 32'(dmem[i]), 32'(m_dm[i]));
            rnd_done = 1'b1;
            rnd_mode = 1'b0;
        end else begin
            model_step();
        end
    endtask

    task automatic tick();
        if (rnd_mode) begin
            imem_ready = ($urandom_range(0, 2) != 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
            halt       = ($urandom_range(0, 7) == 0);
            if (imem_req && imem_ready) model_fetch();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        halt = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        // reset values and first fetch; LI R1,1 / ADD R1,R1 / SHL R1
        fill_nop();
        imem[0] = 8'h55; imem[1] = 8'h05; imem[2] = 8'hA4;
        do_reset();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_r1", rg(1), 32'h0);
        tick();
        check("first_fetch_req", 32'(imem_req), 32'h1);
        check("first_fetch_addr", 32'(imem_addr), 32'h0);
        ticks(6);
        check("prog_r1", rg(1), 32'h4);
        check("prog_pc", 32'(pc), 32'h3);

        // ADD overflow then signed compare
        fill_nop();
        imem[0] = 8'h5D; imem[1] = 8'h68; imem[2] = 8'h0B; imem[3] = 8'h4B;
        dmem[0] = 8'hFF;
        do_reset();
        tick();
        ticks(7);
        check("add_wrap_r2", rg(2), 32'h00);
        ticks(2);
        check("slt_r2", rg(2), 32'h01);

        // LD with 3 wait states
        fill_nop();
        imem[0] = 8'h57; imem[1] = 8'h69;
        dmem[8'hFF] = 8'hA5;
        do_reset();
        tick();
        ticks(2);
        tick();
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_req", 32'(dmem_req), 32'h1);
            check("ld_wait_addr", 32'(dmem_addr), 32'hFF);
            tick();
        end
        dmem_ready = 1'b1;
        check("ld_last_req", 32'(dmem_req), 32'h1);
        check("ld_last_we", 32'(dmem_we), 32'h0);
        tick();
        check("ld_r2", rg(2), 32'hA5);
        check("ld_pc", 32'(pc), 32'h2);
        check("ld_next_fetch", 32'(imem_req), 32'h1);

        // asynchronous reset in the middle of a data wait
        fill_nop();
        imem[0] = 8'h68;
        do_reset();
        dmem_ready = 1'b0;
        ticks(3);
        check("mid_mem_req", 32'(dmem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dmem_req", 32'(dmem_req), 32'h0);
        check("async_rst_pc", 32'(pc), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ready = 1'b1;

        // BEQ not taken, JR, BEQ taken, HALT
        fill_nop();
        imem[0] = 8'h55;
        for (int i = 1; i <= 4; i++) imem[i] = 8'hA4;
        imem[5] = 8'h86; imem[6] = 8'h91;
        imem[8'h10] = 8'h51;
        for (int i = 8'h11; i <= 8'h15; i++) imem[i] = 8'hA0;
        imem[8'h16] = 8'h8B;
        imem[8'h20] = 8'hF0;
        do_reset();
        tick();
        ticks(10);
        check("beq_pre_pc", 32'(pc), 32'h05);
        ticks(2);
        check("beq_ne_pc", 32'(pc), 32'h06);
        ticks(2);
        check("jr_pc", 32'(pc), 32'h10);
        ticks(12);
        check("r0_val", rg(0), 32'h20);
        ticks(2);
        check("beq_eq_pc", 32'(pc), 32'h20);
        ticks(2);
        check("halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h20);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halted_no_req", 32'({imem_req, dmem_req}), 32'h0);
        end
        check("halt_pc_frozen", 32'(pc), 32'h20);

        // halt during a fetch wait
        fill_nop();
        imem[0] = 8'h55;
        do_reset();
        imem_ready = 1'b0;
        tick();
        check("hw_req", 32'(imem_req), 32'h1);
        halt = 1'b1;
        ticks(2);
        check("hw_req_held", 32'(imem_req), 32'h1);
        check("hw_addr_held", 32'(imem_addr), 32'h0);
        imem_ready = 1'b1;
        ticks(2);
        check("hw_r1", rg(1), 32'h1);
        check("hw_pc", 32'(pc), 32'h1);
        for (int i = 0; i < 3; i++) begin
            check("hw_parked", 32'({imem_req, dmem_req}), 32'h0);
            tick();
        end
        halt = 1'b0;
        tick();
        check("hw_resume_req", 32'(imem_req), 32'h1);
        check("hw_resume_addr", 32'(imem_addr), 32'h1);

        // MUL 3 * 5
        fill_nop();
        imem[0] = 8'h55; imem[1] = 8'h59; imem[2] = 8'h09; imem[3] = 8'h09;
        imem[4] = 8'h5D; imem[5] = 8'hAC; imem[6] = 8'hAC; imem[7] = 8'h0D;
        imem[8] = 8'hBB;
        do_reset();
        tick();
        ticks(18);
`ifdef NRISC_MUL_EN
        check("mul_r2", rg(2), 32'd15);
`else
        check("mul_nop_r2", rg(2), 32'd3);
`endif
        check("mul_r3", rg(3), 32'd5);
        check("mul_pc", 32'(pc), 32'd9);

        // random program, random wait states and halt pulses
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'($urandom_range(0, 255));
            if (imem[i][7:4] == 4'hF) imem[i] = 8'hC0;
            dmem[i] = 8'($urandom_range(0, 255));
            m_dm[i] = dmem[i];
        end
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_pc = 8'h00;
        do_reset();
        rnd_mode = 1'b1;
        for (int c = 0; c < 20000 && !rnd_done; c++) tick();
        check("rnd_completed", 32'(rnd_done), 32'h1);
        rnd_mode = 1'b0;
        halt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
